// File: rtl/audio_pkg.sv
// Shared widths, stereo sample layout and count-to-PCM scaling for audio_input.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package audio_pkg;

  localparam int PCM_WIDTH        = 16;
  localparam int ACC_WIDTH        = 17;
  localparam int DROP_COUNT_WIDTH = 8;

  // One stereo sample as it sits in the FIFO and on the data port: R high, L low.
  typedef struct packed {
    logic [PCM_WIDTH-1:0] r;
    logic [PCM_WIDTH-1:0] l;
  } stereo_t;

  // Scale a window count by 2^shift; a 32-bit intermediate lets it clip to full scale instead of wrapping.
  function automatic logic [PCM_WIDTH-1:0] to_pcm(input logic [ACC_WIDTH-1:0] count,
                                                  input logic [3:0]           shift);
    logic [31:0] wide;
    wide = {{(32-ACC_WIDTH){1'b0}}, count} << shift;
    return (wide > 32'h0000_FFFF) ? {PCM_WIDTH{1'b1}} : wide[PCM_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO of 2^ADDR_WIDTH entries with a registered read port.
// Latency: write visible (empty low) the cycle after the push; read data and rd_valid one cycle after rd_en.
// Backpressure: write ignored when full unless a read happens in the same cycle; read ignored when empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  do_rd;
  logic                  do_wr;

  // count never exceeds DEPTH, so its top bit alone means full.
  assign full  = count[ADDR_WIDTH];
  assign empty = (count == '0);
  assign do_rd = rd_en && !empty;
  // A same-cycle read frees the slot, so a write into a full FIFO is still taken.
  assign do_wr = wr_en && (!full || do_rd);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{ADDR_WIDTH{1'b0}}, do_wr} - {{ADDR_WIDTH{1'b0}}, do_rd};
    end
  end

  // Storage array; needs no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Registered read port: data holds between pops, rd_valid pulses once per pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_rd) rd_data <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/audio_input.sv
// Stereo delta-sigma capture: counts ones per window, scales to PCM, queues {R,L}; AUDIO_INPUT_OVERRUN_EN adds drop tracking.
// Latency: 2-cycle input sync; sample pushed on the window-end edge; data/valid one cycle after a popping req.
// Backpressure: none upstream; a window ending on a full FIFO with no same-cycle pop drops that sample.
module audio_input
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH_IN_BITS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ext_audio_r,
  input  logic                        ext_audio_l,
  input  logic [15:0]                 clock_divider,
  input  logic [3:0]                  gain_shift,
  input  logic                        req,
  output logic [31:0]                 data,
  output logic                        valid,
  output logic                        empty,
  output logic                        overrun,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count,
  input  logic                        clear_overrun
);

  logic [1:0]           sync_r;
  logic [1:0]           sync_l;
  logic [15:0]          win_cnt;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH-1:0] acc_l;
  logic [ACC_WIDTH-1:0] sum_r;
  logic [ACC_WIDTH-1:0] sum_l;
  logic                 win_end;
  logic                 fifo_full;
  logic                 pop;
  logic                 drop;
  stereo_t              sample;

  // Two-flop synchronizers for the asynchronous bit streams; bit [1] is the usable bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= '0;
      sync_l <= '0;
    end else begin
      sync_r <= {sync_r[0], ext_audio_r};
      sync_l <= {sync_l[0], ext_audio_l};
    end
  end

  // Window down-counter; clock_divider only matters at reload, so mid-window changes take effect next window.
  always_ff @(posedge clk) begin
    if (reset || win_end) win_cnt <= clock_divider;
    else                  win_cnt <= win_cnt - 1'b1;
  end

  assign win_end = (win_cnt == '0);

  // The window-end cycle's own bit belongs to the closing window, so the pushed count is acc + bit.
  assign sum_r = acc_r + ACC_WIDTH'(sync_r[1]);
  assign sum_l = acc_l + ACC_WIDTH'(sync_l[1]);

  // Per-channel ones counters, restarted at every window end (and on reset, discarding a partial window).
  always_ff @(posedge clk) begin
    if (reset || win_end) begin
      acc_r <= '0;
      acc_l <= '0;
    end else begin
      acc_r <= sum_r;
      acc_l <= sum_l;
    end
  end

  assign sample = {to_pcm(sum_r, gain_shift), to_pcm(sum_l, gain_shift)};
  assign pop    = req && !empty;
  assign drop   = win_end && fifo_full && !pop;

  sync_fifo #(
    .DATA_WIDTH($bits(stereo_t)),
    .ADDR_WIDTH(FIFO_DEPTH_IN_BITS)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (win_end),
    .wr_data  (sample),
    .rd_en    (req),
    .rd_data  (data),
    .rd_valid (valid),
    .full     (fifo_full),
    .empty    (empty)
  );

`ifdef AUDIO_INPUT_OVERRUN_EN
  // Sticky drop tracking; a drop in the same cycle as a clear wins and restarts the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (clear_overrun)          drop_count <= DROP_COUNT_WIDTH'(1);
      else if (drop_count != '1)  drop_count <= drop_count + 1'b1;
    end else if (clear_overrun) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end
  end
`else
  // Drops still happen, they are just not reported.
  assign overrun    = 1'b0;
  assign drop_count = '0;

  logic unused_drop_tracking;
  assign unused_drop_tracking = clear_overrun ^ drop;
`endif

endmodule

// File: tb/tb_audio_input.sv
// Directed bench for audio_input with a scoreboard of expected popped samples.
// Latency: expectations are queued when req is driven and retired by the monitor on valid.
// Backpressure: FIFO fill, drop and simultaneous push/pop cases are driven explicitly.
module tb_audio_input;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ext_audio_r = 1'b0;
  logic        l_const = 1'b1;
  logic        alt_bit = 1'b0;
  logic        alt_en = 1'b0;
  logic        ext_audio_l;
  logic [15:0] clock_divider = 16'd3;
  logic [3:0]  gain_shift = 4'd0;
  logic        req = 1'b0;
  logic        clear_overrun = 1'b0;
  logic [31:0] data;
  logic        valid;
  logic        empty;
  logic        overrun;
  logic [7:0]  drop_count;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];

`ifdef AUDIO_INPUT_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  assign ext_audio_l = alt_en ? alt_bit : l_const;

  audio_input #(.FIFO_DEPTH_IN_BITS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ext_audio_r   (ext_audio_r),
    .ext_audio_l   (ext_audio_l),
    .clock_divider (clock_divider),
    .gain_shift    (gain_shift),
    .req           (req),
    .data          (data),
    .valid         (valid),
    .empty         (empty),
    .overrun       (overrun),
    .drop_count    (drop_count),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  // Alternating stream source for the gain test.
  initial forever begin
    @(posedge clk);
    #1;
    alt_bit = ~alt_bit;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // Queue the expected sample and raise req for one edge; caller drops req.
  task automatic issue_req(input logic [31:0] e);
    exp_q.push_back(e);
    req = 1'b1;
    step(1);
  endtask

  // Monitor: every valid pulse retires one expected sample.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) chk("valid_without_expectation", {31'b0, valid}, 32'd0);
      else                   chk("popped_sample", data, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    // Constant L=1,R=0 windows of 4, then R=1 and a 65536-cycle window.
    do_reset();
    chk("reset_data", data, 32'd0);
    chk("reset_valid", {31'b0, valid}, 32'd0);
    chk("reset_empty", {31'b0, empty}, 32'd1);
    chk("reset_overrun", {31'b0, overrun}, 32'd0);
    chk("reset_drop_count", {24'b0, drop_count}, 32'd0);
    step(3);
    chk("empty_before_first_window", {31'b0, empty}, 32'd1);
    step(1);
    chk("empty_after_first_window", {31'b0, empty}, 32'd0);
    step(4);
    ext_audio_r   = 1'b1;
    clock_divider = 16'hFFFF;
    step(65541);
    issue_req(32'h0000_0002);
    issue_req(32'h0000_0004);
    issue_req(32'h0002_0004);
    issue_req(32'hFFFF_FFFF);
    req = 1'b0;
    step(2);
    chk("empty_after_drain", {31'b0, empty}, 32'd1);

    // Alternating L, 8-cycle windows, gain 12 then 15.
    ext_audio_r   = 1'b0;
    clock_divider = 16'd7;
    gain_shift    = 4'd12;
    alt_en        = 1'b1;
    do_reset();
    step(16);
    gain_shift = 4'd15;
    step(8);
    issue_req(32'h0000_3000);
    issue_req(32'h0000_4000);
    issue_req(32'h0000_FFFF);
    req    = 1'b0;
    alt_en = 1'b0;
    step(2);

    // Fill the 16-deep FIFO, drop 2, clear/drop precedence, then push+pop on full.
    clock_divider = 16'd3;
    gain_shift    = 4'd0;
    l_const       = 1'b1;
    do_reset();
    step(64);
    chk("overrun_at_16_samples", {31'b0, overrun}, 32'd0);
    chk("drops_at_16_samples", {24'b0, drop_count}, 32'd0);
    chk("not_empty_when_full", {31'b0, empty}, 32'd0);
    step(4);
    chk("overrun_after_17_windows", {31'b0, overrun}, OVR_EN ? 32'd1 : 32'd0);
    chk("drops_after_17_windows", {24'b0, drop_count}, OVR_EN ? 32'd1 : 32'd0);
    step(4);
    chk("overrun_after_18_windows", {31'b0, overrun}, OVR_EN ? 32'd1 : 32'd0);
    chk("drops_after_18_windows", {24'b0, drop_count}, OVR_EN ? 32'd2 : 32'd0);
    step(3);
    clear_overrun = 1'b1;
    step(1);
    clear_overrun = 1'b0;
    chk("overrun_drop_beats_clear", {31'b0, overrun}, OVR_EN ? 32'd1 : 32'd0);
    chk("drops_drop_beats_clear", {24'b0, drop_count}, OVR_EN ? 32'd1 : 32'd0);
    step(1);
    clear_overrun = 1'b1;
    step(1);
    clear_overrun = 1'b0;
    chk("overrun_after_clear", {31'b0, overrun}, 32'd0);
    chk("drops_after_clear", {24'b0, drop_count}, 32'd0);
    step(1);
    for (int i = 0; i < 20; i++) begin
      issue_req((i == 0) ? 32'h0000_0002 : 32'h0000_0004);
      if (i == 0) begin
        chk("no_drop_on_full_push_pop", {24'b0, drop_count}, 32'd0);
        chk("no_overrun_on_full_push_pop", {31'b0, overrun}, 32'd0);
      end
    end
    req = 1'b0;
    step(2);

    // req while empty is ignored; later push then req returns the sample.
    do_reset();
    req = 1'b1;
    step(1);
    chk("valid_req_empty_1", {31'b0, valid}, 32'd0);
    chk("empty_req_empty_1", {31'b0, empty}, 32'd1);
    step(1);
    chk("valid_req_empty_2", {31'b0, valid}, 32'd0);
    chk("empty_req_empty_2", {31'b0, empty}, 32'd1);
    req = 1'b0;
    step(3);
    issue_req(32'h0000_0002);
    req = 1'b0;
    chk("valid_one_cycle_after_req", {31'b0, valid}, 32'd1);
    chk("data_one_cycle_after_req", data, 32'h0000_0002);
    step(1);
    chk("valid_is_single_pulse", {31'b0, valid}, 32'd0);
    chk("data_held_between_pops", data, 32'h0000_0002);

    // Reset mid-window with 3 ones accumulated.
    clock_divider = 16'd7;
    do_reset();
    chk("data_cleared_by_reset", data, 32'd0);
    chk("empty_after_reset", {31'b0, empty}, 32'd1);
    step(5);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk("empty_after_midwindow_reset", {31'b0, empty}, 32'd1);
    chk("valid_after_midwindow_reset", {31'b0, valid}, 32'd0);
    step(7);
    chk("empty_before_post_reset_window", {31'b0, empty}, 32'd1);
    step(1);
    chk("empty_after_post_reset_window", {31'b0, empty}, 32'd0);
    issue_req(32'h0000_0006);
    req = 1'b0;
    step(3);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
